pixel_keystream_cipher: RTL
===========================

// Module: pixel_keystream_cipher
// PURPOSE
//   Consumes the 8-bit keystream bytes produced by the chaotic mixer and applies them to a raster pixel stream.
//   Encrypt mode: C[i] = ((P[i] + K[i]) mod 256) ^ C[i-1].
//   Decrypt mode (exact inverse): P[i] = ((C[i] ^ C[i-1]) - K[i]) mod 256.
//   The chain seed C[-1] is the per-frame IV. The block sits between the keystream path and the image memory/stream DMA.
// PARAMETERS
//   KS_W   23  width of keystream input word; only bits [7:0] are used
//   CNT_W  20  width of frame pixel counter and frame_len
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   start      in   1      one-cycle pulse; latches mode, iv, frame_len; honoured only in IDLE
//   mode       in   1      0 = encrypt, 1 = decrypt
//   iv         in   8      chain seed C[-1]
//   frame_len  in   CNT_W  pixels in the frame; 0 is legal
//   ks_valid   in   1      keystream word available
//   ks_data    in   KS_W   keystream word; [KS_W-1:8] ignored
//   ks_ready   out  1      keystream word consumed this cycle
//   pix_valid  in   1      input pixel (plaintext or ciphertext) available
//   pix_data   in   8      input pixel
//   pix_ready  out  1      input pixel consumed this cycle
//   out_valid  out  1      output pixel valid
//   out_data   out  8      output pixel
//   out_last   out  1      qualifies the final pixel of the frame
//   out_ready  in   1      downstream accepts out_data
//   busy       out  1      high in RUN or FLUSH
//   done       out  1      one-cycle pulse when the frame has fully drained
// BEHAVIOUR
//   Reset: all outputs = 0; state = IDLE; counter, chain register and latched config cleared.
//   FSM states:
//   - IDLE: on start, latch config and set chain = iv. Go to RUN if frame_len != 0.
//     If frame_len == 0, go to FLUSH with nothing pending; done pulses on the next cycle.
//   - RUN: fire = ks_valid & pix_valid & (!out_valid | out_ready).
//     ks_ready = pix_ready = fire; both inputs are always consumed together (join).
//     On fire:
//     - out_data <= result; out_valid <= 1; count++.
//     - chain <= C[i]: the produced ciphertext when encrypting, pix_data when decrypting.
//     - On fire with count == frame_len-1: out_last <= 1, then go to FLUSH.
//   - FLUSH: no input consumed. When the output register is empty or being accepted (out_ready):
//     done <= 1 for one cycle, state <= IDLE.
//   Output register:
//   - out_valid clears on out_ready when there is no new fire in the same cycle.
//   - out_data and out_last are held stable while out_valid & !out_ready.
//   - Simultaneous accept and fire: the new pixel replaces the old one in the same cycle, with no bubble.
//   Latency: 1 cycle from fire to out_valid. Throughput: 1 pixel/cycle when all sides stream.
//   Arithmetic: 8-bit; add and subtract wrap modulo 256; no saturation.
//   start while busy is ignored; the latched config stays unchanged for the whole frame.
//   A keystream word is never consumed without a pixel, and a pixel never without a keystream word.
//   Asserting rst mid-frame aborts immediately: the partial output is dropped, no done pulse, state = IDLE.
//   The counter never wraps within a frame because frame_len is bounded by CNT_W.
// TESTING
//   1. Encrypt, iv=0x00, frame_len=2, P={0x10,0x20}, K={0x05,0x30}
//      -> out={0x15,0x45}; out_last on 0x45; done 1 cycle after last accept.
//   2. Decrypt, iv=0x00, frame_len=2, C={0x15,0x45}, K={0x05,0x30}
//      -> out={0x10,0x20}; round-trips test 1.
//   3. Wrap: encrypt P=0xF0, K=0x20, iv=0x00 -> 0x10. Decrypt C=0x10, K=0x20, iv=0x00 -> 0xF0.
//      ks_data=0x7FFF05 behaves as K=0x05.
//   4. Backpressure: hold out_ready=0 for 5 cycles mid-frame
//      -> ks_ready = pix_ready = 0; out_data held; no pixel lost or duplicated.
//      Random ks_valid/pix_valid gaps: 256-pixel frame matches the reference model.
//   5. frame_len=0 -> no transfers; done 2 cycles after start.
//      start during RUN -> ignored; frame completes with the original iv and length.
//   6. rst asserted after 3 of 8 pixels -> outputs 0, state IDLE.
//      A new start with iv=0xA5 produces a correct fresh chain.

Source files
------------

// File: rtl/pixel_keystream_cipher.sv
`default_nettype none
// ============================================================================
// Module   : pixel_keystream_cipher
// Purpose  : Chained keystream cipher for a raster pixel stream.
//            Encrypt: C[i] = ((P[i] + K[i]) mod 256) ^ C[i-1]
//            Decrypt: P[i] = ((C[i] ^ C[i-1]) - K[i]) mod 256
//            C[-1] is the per-frame IV latched on start.
// Ports    : clk, rst (async, active-high)
//            start/mode/iv/frame_len  - frame configuration, taken in IDLE only
//            ks_valid/ks_data/ks_ready  - keystream input (bits [7:0] used)
//            pix_valid/pix_data/pix_ready - input pixel stream
//            out_valid/out_data/out_last/out_ready - registered output stream
//            busy  - frame in progress (RUN or FLUSH)
//            done  - one-cycle pulse once the frame has fully drained
// Revision : 1.0 - initial release
// ============================================================================
module pixel_keystream_cipher #(
  parameter int KS_W  = 23,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [7:0]       iv,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             ks_valid,
  input  logic [KS_W-1:0]  ks_data,
  output logic             ks_ready,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count;
  logic [7:0]       chain;
  logic             fire;
  logic             drain;
  logic             last_pix;
  logic [7:0]       key;
  logic [7:0]       enc_result;
  logic [7:0]       dec_result;
  logic [7:0]       result;
  logic [7:0]       next_chain;

  // Only the low keystream byte carries key material.
  logic unused_ks_hi;
  assign unused_ks_hi = ^ks_data[KS_W-1:8];

  assign key        = ks_data[7:0];
  assign enc_result = (pix_data + key) ^ chain;
  assign dec_result = (pix_data ^ chain) - key;
  assign result     = mode_q ? dec_result : enc_result;
  // The chain always follows the ciphertext: produced value when
  // encrypting, the incoming pixel when decrypting.
  assign next_chain = mode_q ? pix_data : enc_result;
  // len_q is never zero while in RUN, so len_q-1 cannot underflow there.
  assign last_pix   = (count == (len_q - CNT_W'(1)));

  assign ks_ready  = fire;
  assign pix_ready = fire;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (frame_len == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        // Join: keystream and pixel are consumed only together, and only
        // when the output register can take the result.
        fire = ks_valid & pix_valid & (~out_valid | out_ready);
        if (fire && last_pix) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        drain = ~out_valid | out_ready;
        if (drain) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      len_q     <= '0;
      count     <= '0;
      chain     <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= drain;
      if (state == IDLE && start) begin
        mode_q <= mode;
        len_q  <= frame_len;
        count  <= '0;
        chain  <= iv;
      end
      if (fire) begin
        // A fire in the same cycle as an accept replaces the old pixel.
        out_valid <= 1'b1;
        out_data  <= result;
        out_last  <= last_pix;
        count     <= count + CNT_W'(1);
        chain     <= next_chain;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
